// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types for the pipelined adder scheduler
package adder_sched_pkg;

  // Scheduler control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Requester id field is sized for the largest supported NREQ (16)
  localparam int TAG_ID_W = 4;

  // One slot of the tag pipe that shadows the external adder
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  // Scan from ptr upward (wrapping) and grant the first requester found
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder_scheduler.sv
// rtl/pipelined_adder_scheduler.sv - round-robin issue into an external WIDTH-stage adder; optional ADDER_SCHED_STATS_EN counters
module pipelined_adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_c,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_c,
  input  logic [WIDTH-1:0]        add_s,
  input  logic                    add_carry,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    idle
`ifdef ADDER_SCHED_STATS_EN
  ,
  output logic [31:0]             stat_issued,
  output logic [31:0]             stat_busy
`endif
);

  localparam int ID_W = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt;
  logic              fire;
  logic              pipe_busy;
  logic [ID_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              sel_c;
  logic [WIDTH-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
  logic              add_c_q, add_c_d;
  tag_t              tag_q [WIDTH];
  tag_t              tag_d [WIDTH];
  tag_t              tag_out;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Grants are only exposed while running; a handshake is any granted valid
  always_comb begin
    req_ready = (state_q == RUN) ? gnt : '0;
    fire      = |(req_valid & req_ready);
  end

  // Encode the one-hot grant and mux the winning requester's operands
  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_c   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        gnt_idx = ID_W'(i);
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_c   = req_c[i];
      end
    end
  end

  // Any occupied tag slot means results are still owed
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      pipe_busy = pipe_busy | tag_q[i].valid;
    end
  end

  // Next state: DRAIN waits for the tag pipe to empty unless re-enabled
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)              state_d = RUN;
        else if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer moves past the winner; operands hold when nothing is issued
  always_comb begin
    ptr_d   = ptr_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    add_c_d = add_c_q;
    if (fire) begin
      ptr_d   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      add_a_d = sel_a;
      add_b_d = sel_b;
      add_c_d = sel_c;
    end
  end

  // Tag pipe shifts every cycle; a cycle without a grant inserts an empty slot
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      tag_d[i] = '0;
    end
    tag_d[0].valid = fire;
    tag_d[0].id    = TAG_ID_W'(gnt_idx);
    for (int i = 1; i < WIDTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // The last tag slot lines up with the adder result; data holds when empty
  always_comb begin
    tag_out     = tag_q[WIDTH-1];
    rsp_valid_d = tag_out.valid;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    if (tag_out.valid) begin
      rsp_id_d   = tag_out.id[ID_W-1:0];
      rsp_sum_d  = add_s;
      rsp_cout_d = add_carry;
    end
  end

  // All scheduler state; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_c_q     <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        tag_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_c_q     <= add_c_d;
      for (int i = 0; i < WIDTH; i++) begin
        tag_q[i] <= tag_d[i];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_c     = add_c_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign idle      = (state_q == IDLE) && !pipe_busy;

`ifdef ADDER_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_busy_q, stat_busy_d;

  // Free-running wrapping counters of issues and occupied-pipe cycles
  always_comb begin
    stat_issued_d = stat_issued_q + (fire ? 32'd1 : 32'd0);
    stat_busy_d   = stat_busy_q + (pipe_busy ? 32'd1 : 32'd0);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_busy_q   <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_busy_q   <= stat_busy_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_busy   = stat_busy_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_scheduler.sv
// tb/tb_pipelined_adder_scheduler.sv - directed self-checking bench for pipelined_adder_scheduler
module tb_pipelined_adder_scheduler;

  localparam int W = 3;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_c;
  logic [W-1:0]   add_a, add_b, add_s;
  logic           add_c, add_carry;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           idle;
`ifdef ADDER_SCHED_STATS_EN
  logic [31:0]    stat_issued, stat_busy;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int mon_cyc[$], mon_id[$], mon_sum[$], mon_cout[$];
  int mon_hs_cyc[$], mon_hs_idx[$];

  pipelined_adder_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_s(add_s), .add_carry(add_carry),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .idle(idle)
`ifdef ADDER_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_busy(stat_busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External adder: WIDTH cycles from add_a update to capture
  logic [W:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c};
    s2 <= s1;
  end
  assign add_s     = s2[W-1:0];
  assign add_carry = s2[W];

  // Recorder of handshakes and responses
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      mon_cyc.push_back(cyc); mon_id.push_back(int'(rsp_id));
      mon_sum.push_back(int'(rsp_sum)); mon_cout.push_back(int'(rsp_cout));
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] === 1'b1) begin
        mon_hs_cyc.push_back(cyc); mon_hs_idx.push_back(i);
      end
    end
  end

  task automatic clear_mon();
    mon_cyc.delete(); mon_id.delete(); mon_sum.delete(); mon_cout.delete();
    mon_hs_cyc.delete(); mon_hs_idx.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 40 && mon_cyc.size() < n; i++) tick();
    n_checks++;
    if (mon_cyc.size() < n) begin n_fail++; $display("FAIL wait_rsp: got %0d results want %0d", mon_cyc.size(), n); end
  endtask

  task automatic set_ops(input int k, input int a, input int b, input int c);
    logic [31:0] va, vb, vc;
    va = a; vb = b; vc = c;
    req_a[k*W +: W] = va[W-1:0];
    req_b[k*W +: W] = vb[W-1:0];
    req_c[k]        = vc[0];
  endtask

  task automatic issue_one(input int k, input int a, input int b, input int c, output int hs);
    set_ops(k, a, b, c);
    req_valid = '0; req_valid[k] = 1'b1;
    hs = -1;
    for (int i = 0; i < 20 && hs < 0; i++) begin
      @(negedge clk);
      if (req_ready[k] === 1'b1) hs = cyc;
      tick();
    end
    req_valid = '0;
    n_checks++;
    if (hs < 0) begin n_fail++; $display("FAIL issue_timeout: requester %0d got no grant, want grant", k); end
  endtask

  task automatic check_single(input string nm, input int hs, input int k, input int s, input int co);
    wait_rsp(1);
    if (mon_cyc.size() >= 1) begin
      n_checks++; if (mon_cyc[0] - hs != W + 1) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", nm, mon_cyc[0] - hs, W + 1); end
      n_checks++; if (mon_id[0] != k) begin n_fail++; $display("FAIL %s_id: got %0d want %0d", nm, mon_id[0], k); end
      n_checks++; if (mon_sum[0] != s) begin n_fail++; $display("FAIL %s_sum: got %0d want %0d", nm, mon_sum[0], s); end
      n_checks++; if (mon_cout[0] != co) begin n_fail++; $display("FAIL %s_cout: got %0d want %0d", nm, mon_cout[0], co); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    #12;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (add_a !== '0 || add_b !== '0 || add_c !== 1'b0) begin n_fail++; $display("FAIL reset_add_ops: got %0d %0d %b want 0 0 0", add_a, add_b, add_c); end
    n_checks++; if (rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %0d %b %0d want 0 0 0", rsp_sum, rsp_cout, rsp_id); end
    tick(); rst_n = 1'b1;
    req_valid = 3'b111;
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready_in_idle: got %b want 000", req_ready); end
    tick(); req_valid = '0;
  endtask

  task automatic test_single();
    int hs;
    clear_mon(); en = 1'b1;
    issue_one(1, 2, 1, 1, hs);
    check_single("single", hs, 1, 4, 0);
    n_checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 3'd4) begin n_fail++; $display("FAIL single_hold: got valid %b sum %0d want 0 4", rsp_valid, rsp_sum); end
  endtask

  task automatic test_carry();
    int hs;
    clear_mon();
    issue_one(2, 7, 7, 1, hs);
    check_single("carry", hs, 2, 7, 1);
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    int es[3] = '{3, 6, 2};
    int ec[3] = '{0, 0, 1};
    clear_mon();
    set_ops(0, 1, 2, 0); set_ops(1, 2, 3, 1); set_ops(2, 6, 4, 0);
    req_valid = 3'b111;
    for (int i = 0; i < 30 && cnt < 6; i++) begin
      @(negedge clk); if (|(req_valid & req_ready)) cnt++;
      tick(); if (cnt == 6) req_valid = '0;
    end
    req_valid = '0;
    wait_rsp(6);
    repeat (6) tick();
    n_checks++; if (mon_hs_idx.size() != 6) begin n_fail++; $display("FAIL b2b_grant_count: got %0d want 6", mon_hs_idx.size()); end
    n_checks++; if (mon_cyc.size() != 6) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 6", mon_cyc.size()); end
    if (mon_hs_idx.size() == 6 && mon_cyc.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (mon_hs_idx[i] != i % 3 || mon_hs_cyc[i] != mon_hs_cyc[0] + i) begin n_fail++; $display("FAIL b2b_grant%0d: got idx %0d cyc +%0d want idx %0d cyc +%0d", i, mon_hs_idx[i], mon_hs_cyc[i] - mon_hs_cyc[0], i % 3, i); end
        n_checks++; if (mon_id[i] != i % 3 || mon_sum[i] != es[i % 3] || mon_cout[i] != ec[i % 3] || mon_cyc[i] != mon_hs_cyc[i] + W + 1) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got id %0d sum %0d cout %0d lat %0d want %0d %0d %0d %0d", i, mon_id[i], mon_sum[i], mon_cout[i], mon_cyc[i] - mon_hs_cyc[i], i % 3, es[i % 3], ec[i % 3], W + 1);
        end
      end
    end
  endtask

  task automatic test_drain();
    int cnt = 0;
    int es[3] = '{3, 6, 2};
    bit seen_idle = 0;
    clear_mon();
    req_valid = 3'b111;
    for (int i = 0; i < 30 && cnt < 2; i++) begin
      @(negedge clk); if (|(req_valid & req_ready)) cnt++;
      tick();
    end
    en = 1'b0;
    @(negedge clk);
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL drain_busy_idle: got %b want 0", idle); end
    tick();
    repeat (10) tick();
    n_checks++; if (mon_hs_idx.size() != 3) begin n_fail++; $display("FAIL drain_issues: got %0d want 3", mon_hs_idx.size()); end
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL drain_ready: got %b want 000", req_ready); end
    req_valid = '0;
    for (int i = 0; i < 20 && !seen_idle; i++) begin @(negedge clk); if (idle === 1'b1) seen_idle = 1; tick(); end
    n_checks++; if (!seen_idle) begin n_fail++; $display("FAIL drain_idle: got 0 want 1"); end
    n_checks++; if (mon_cyc.size() != 3) begin n_fail++; $display("FAIL drain_rsp_count: got %0d want 3", mon_cyc.size()); end
    if (mon_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (mon_id[i] != i || mon_sum[i] != es[i]) begin n_fail++; $display("FAIL drain_rsp%0d: got id %0d sum %0d want %0d %0d", i, mon_id[i], mon_sum[i], i, es[i]); end
      end
    end
  endtask

  task automatic test_patterns();
    int tk[4] = '{0, 1, 2, 0};
    int ta[4] = '{5, 0, 3, 6};
    int tb[4] = '{4, 0, 4, 1};
    int tc[4] = '{0, 0, 1, 0};
    int ts[4] = '{1, 0, 0, 7};
    int tco[4] = '{1, 0, 1, 0};
    int hs;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      issue_one(tk[i], ta[i], tb[i], tc[i], hs);
      check_single($sformatf("pat%0d", i), hs, tk[i], ts[i], tco[i]);
    end
  endtask

  task automatic test_reset_midflight();
    int cnt = 0;
    int hs;
    en = 1'b1; req_valid = 3'b011;
    for (int i = 0; i < 30 && cnt < 2; i++) begin
      @(negedge clk); if (|(req_valid & req_ready)) cnt++;
      tick(); if (cnt == 2) req_valid = '0;
    end
    req_valid = '0;
    #2; rst_n = 1'b0; #1;
    clear_mon();
    n_checks++; if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin n_fail++; $display("FAIL midrst_rsp: got %b %0d %b %0d want 0 0 0 0", rsp_valid, rsp_sum, rsp_cout, rsp_id); end
    n_checks++; if (add_a !== '0 || add_b !== '0 || add_c !== 1'b0) begin n_fail++; $display("FAIL midrst_add_ops: got %0d %0d %b want 0 0 0", add_a, add_b, add_c); end
    req_valid = 3'b111; #1;
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_ready: got %b want 000", req_ready); end
    req_valid = '0;
    tick(); tick(); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got %b want 1", idle); end
    tick();
    repeat (12) tick();
    n_checks++; if (mon_cyc.size() != 0) begin n_fail++; $display("FAIL midrst_stale_rsp: got %0d results want 0", mon_cyc.size()); end
    issue_one(2, 1, 1, 0, hs);
    check_single("post_rst", hs, 2, 2, 0);
  endtask

`ifdef ADDER_SCHED_STATS_EN
  task automatic test_stats();
    int cnt = 0;
    rst_n = 1'b0; req_valid = '0; tick(); rst_n = 1'b1; en = 1'b1;
    n_checks++; if (stat_issued !== 32'd0 || stat_busy !== 32'd0) begin n_fail++; $display("FAIL stats_reset: got %0d %0d want 0 0", stat_issued, stat_busy); end
    req_valid = 3'b111;
    for (int i = 0; i < 30 && cnt < 5; i++) begin
      @(negedge clk); if (|(req_valid & req_ready)) cnt++;
      tick(); if (cnt == 5) req_valid = '0;
    end
    req_valid = '0;
    repeat (12) tick();
    n_checks++; if (stat_issued !== 32'd5) begin n_fail++; $display("FAIL stats_issued: got %0d want 5", stat_issued); end
    n_checks++; if (stat_busy !== 32'd7) begin n_fail++; $display("FAIL stats_busy: got %0d want 7", stat_busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_drain();
    test_patterns();
    test_reset_midflight();
`ifdef ADDER_SCHED_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_scheduler.md
PIPELINED_ADDER_SCHEDULER -- requirements
Module: pipelined_adder_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width and adder pipeline latency in cycles.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, 2..16.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: run enable; low requests drain and stop.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester operation valid.
REQ-007 SHALL have port req_ready, output, NREQ: per-requester grant, one-hot or zero.
REQ-008 SHALL have port req_a, input, NREQ*WIDTH: operand A, requester k in bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port req_b, input, NREQ*WIDTH: operand B, same packing.
REQ-010 SHALL have port req_c, input, NREQ: carry-in per requester.
REQ-011 SHALL have ports add_a, add_b, output, WIDTH each; add_c, output, 1: registered adder operands.
REQ-012 SHALL have ports add_s, input, WIDTH; add_carry, input, 1: adder sum and carry-out.
REQ-013 SHALL have port rsp_valid, output, 1: result valid, no backpressure.
REQ-014 SHALL have port rsp_id, output, clog2(NREQ): requester owning the result.
REQ-015 SHALL have ports rsp_sum, output, WIDTH; rsp_cout, output, 1: result data.
REQ-016 SHALL have port idle, output, 1: high when state IDLE and pipeline empty.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->IDLE when tag pipe empty; DRAIN->RUN when en=1.
REQ-018 SHALL grant at most one requester per cycle, only in RUN, via round-robin starting after the last granted index; the first grant after reset prefers index 0.
REQ-019 SHALL complete a transfer when req_valid[k] and req_ready[k] are both high; req_ready[k] SHALL depend combinationally on req_valid and the registered pointer only.
REQ-020 SHALL register granted operands into add_a/add_b/add_c at the handshake edge; on a cycle without a grant it SHALL hold operands and mark the slot invalid.
REQ-021 SHALL carry a WIDTH-deep tag shift register {valid, id}, advancing every cycle, aligned so add_s/add_carry are captured exactly WIDTH cycles after add_a updates.
REQ-022 SHALL return rsp_valid/rsp_id/rsp_sum/rsp_cout registered, giving a total latency of WIDTH+1 cycles from handshake to rsp_valid.
REQ-023 SHALL keep rsp_sum = (a+b+c) mod 2^WIDTH and rsp_cout = bit WIDTH of that sum, as supplied by the adder, unmodified.
REQ-024 SHALL sustain one issue per cycle with no bubbles while any request is pending in RUN.
REQ-025 SHALL never drop or reorder in-flight operations on en deassertion; DRAIN emits all remaining results in issue order.
REQ-026 SHALL keep rsp_valid low in cycles whose tag slot is invalid; rsp_sum/rsp_cout SHALL hold their last value.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear state to IDLE, the RR pointer to 0, all tag valids, add_a/add_b/add_c, rsp_valid, rsp_id, rsp_sum and rsp_cout to 0; idle SHALL read 1 once reset is released.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no rsp_valid for them follows.

Configuration
REQ-029 SHALL, with ADDER_SCHED_STATS_EN defined, add output stat_issued (32-bit count of handshakes) and stat_busy (32-bit count of cycles with any valid tag), both wrapping and reset to 0; without the macro, neither port nor its logic SHALL exist.

Structure
REQ-030 SHALL place the state enum (IDLE/RUN/DRAIN) and the tag struct {valid, id} in package adder_sched_pkg.
REQ-031 SHALL isolate the round-robin grant logic in sub-module rr_arbiter (parameter N; ports req, ptr, gnt).

Verification
REQ-032 SHALL cover: WIDTH=3, NREQ=3, en=1, single request k=1 with a=2, b=1, c=1 -> rsp_valid 4 cycles later, rsp_id=1, rsp_sum=4, rsp_cout=0.
REQ-033 SHALL cover: all three requesters valid continuously -> grants 0,1,2,0,1,2 on consecutive cycles and results in the same order, none missing.
REQ-034 SHALL cover: a=7, b=7, c=1 at WIDTH=3 -> rsp_sum=7, rsp_cout=1.
REQ-035 SHALL cover: en dropped one cycle after 3 issues -> no further req_ready, 3 results emitted, then idle=1.
REQ-036 SHALL cover: rst_n pulsed low with 2 ops in flight -> outputs 0 immediately, no rsp_valid afterwards until new requests.
REQ-037 SHALL cover, with ADDER_SCHED_STATS_EN: 5 issues -> stat_issued=5 and stat_busy equals the cycles with an occupied pipeline.
